xc3_clk_seq: RTL

XC3_CLK_SEQ -- requirements
Module: xc3_clk_seq

---
 rtl/xc3_clk_seq.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/xc3_clk_seq.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : xc3_clk_seq
// Brief    : Two-stage DCM bring-up sequencer. Holds the stage-1 DCM in
//            reset, waits for a stable lock, then repeats for the stage-2
//            DCMs, and finally releases the SYS, VIDEO and UART domain resets
//            one cycle apart. Loss of lock or a lock timeout either retries
//            the affected stage or parks the block in FAULT.
// Config   : XC3_CLK_SEQ_AUTORETRY_EN - when defined, timeouts and loss of
//            lock in RUN retry the affected stage; when undefined, they go
//            straight to FAULT and the retry counter stays at zero.
// Revision : 1.0 - initial release
// ============================================================================
module xc3_clk_seq #(
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65535
) (
  input  logic       I_CLK50M,
  input  logic       I_RESET_N,
  input  logic       I_LOCK90M,
  input  logic       I_LOCK28M636,
  input  logic       I_LOCK32M,
  input  logic       I_LOCK24M,
  output logic       O_DCM1_RESET,
  output logic       O_DCM2_RESET,
  output logic       O_RST_SYS_N,
  output logic       O_RST_VIDEO_N,
  output logic       O_RST_UART_N,
  output logic       O_READY,
  output logic       O_FAULT,
  output logic [2:0] O_STATE,
  output logic [3:0] O_RETRY_CNT
);

`ifdef XC3_CLK_SEQ_AUTORETRY_EN
  localparam bit c_AUTORETRY = 1'b1;
`else
  localparam bit c_AUTORETRY = 1'b0;
`endif

  // The phase counter times both the DCM reset hold and the three-step
  // release, so it needs at least two bits even for very short holds.
  localparam int c_HOLD_W = (RST_HOLD_CYC > 3) ? $clog2(RST_HOLD_CYC) : 2;
  localparam int c_STB_W  = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
  localparam int c_TMO_W  = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;

  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_HOLD_CYC - 1);
  localparam logic [c_HOLD_W-1:0] c_REL_VID   = c_HOLD_W'(1);
  localparam logic [c_HOLD_W-1:0] c_REL_UART  = c_HOLD_W'(2);
  localparam logic [c_STB_W-1:0]  c_STB_LAST  = c_STB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [3:0]          c_RETRY_MAX = 4'hF;

  typedef enum logic [2:0] {
    ST_RST1  = 3'd0,
    ST_WAIT1 = 3'd1,
    ST_RST2  = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_REL   = 3'd4,
    ST_RUN   = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  // Lock bit order in the synchronizer: {lock90, lock28m636, lock32m, lock24m}
  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_HOLD_W-1:0] r_cnt;
  logic [c_HOLD_W-1:0] w_cnt_nxt;
  logic [c_STB_W-1:0]  r_stb;
  logic [c_STB_W-1:0]  w_stb_nxt;
  logic [c_TMO_W-1:0]  r_tmo;
  logic [c_TMO_W-1:0]  w_tmo_nxt;
  logic [3:0]          r_retry;
  logic [3:0]          w_retry_nxt;
  logic [3:0]          w_retry_inc;
  logic                w_lock90;
  logic                w_lock_all;

  assign w_lock90    = r_sync2[3];
  assign w_lock_all  = &r_sync2;
  assign w_retry_inc = (r_retry == c_RETRY_MAX) ? c_RETRY_MAX : r_retry + 4'd1;

  assign O_STATE     = r_state;
  assign O_RETRY_CNT = r_retry;

  // Two-flop synchronizer for the asynchronous DCM lock indications.
  always_ff @(posedge I_CLK50M) begin
    if (!I_RESET_N) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= {I_LOCK90M, I_LOCK28M636, I_LOCK32M, I_LOCK24M};
      r_sync2 <= r_sync1;
    end
  end

  // State register together with the phase, stability, timeout and retry counters.
  always_ff @(posedge I_CLK50M) begin
    if (!I_RESET_N) begin
      r_state <= ST_RST1;
      r_cnt   <= '0;
      r_stb   <= '0;
      r_tmo   <= '0;
      r_retry <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stb   <= w_stb_nxt;
      r_tmo   <= w_tmo_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  // Next-state, counter-update and output decode. Domain resets and READY in
  // RUN follow the synchronized locks directly so a loss of lock pulls them
  // low in the very cycle it is seen, before the state has moved.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_stb_nxt     = '0;
    w_tmo_nxt     = '0;
    w_retry_nxt   = r_retry;
    O_DCM1_RESET  = 1'b0;
    O_DCM2_RESET  = 1'b0;
    O_RST_SYS_N   = 1'b0;
    O_RST_VIDEO_N = 1'b0;
    O_RST_UART_N  = 1'b0;
    O_READY       = 1'b0;
    O_FAULT       = 1'b0;

    case (r_state)
      ST_RST1: begin
        O_DCM1_RESET = 1'b1;
        O_DCM2_RESET = 1'b1;
        if (r_cnt == c_HOLD_LAST) begin
          w_state_nxt = ST_WAIT1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_WAIT1: begin
        O_DCM2_RESET = 1'b1;
        w_stb_nxt    = w_lock90 ? r_stb + 1'b1 : '0;
        w_tmo_nxt    = r_tmo + 1'b1;
        if (w_lock90 && (r_stb == c_STB_LAST)) begin
          w_state_nxt = ST_RST2;
        end else if (r_tmo == c_TMO_LAST) begin
          if (c_AUTORETRY) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = (w_retry_inc == c_RETRY_MAX) ? ST_FAULT : ST_RST1;
          end else begin
            w_state_nxt = ST_FAULT;
          end
        end
      end

      ST_RST2: begin
        O_DCM2_RESET = 1'b1;
        if (r_cnt == c_HOLD_LAST) begin
          w_state_nxt = ST_WAIT2;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_WAIT2: begin
        w_stb_nxt = w_lock_all ? r_stb + 1'b1 : '0;
        w_tmo_nxt = r_tmo + 1'b1;
        // Losing the stage-1 lock invalidates every stage-2 DCM, so the whole
        // chain restarts; this is not a timeout and does not count as a retry.
        if (!w_lock90) begin
          w_state_nxt = ST_RST1;
        end else if (w_lock_all && (r_stb == c_STB_LAST)) begin
          w_state_nxt = ST_REL;
        end else if (r_tmo == c_TMO_LAST) begin
          if (c_AUTORETRY) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = (w_retry_inc == c_RETRY_MAX) ? ST_FAULT : ST_RST2;
          end else begin
            w_state_nxt = ST_FAULT;
          end
        end
      end

      ST_REL: begin
        O_RST_SYS_N   = 1'b1;
        O_RST_VIDEO_N = (r_cnt >= c_REL_VID);
        O_RST_UART_N  = (r_cnt >= c_REL_UART);
        if (r_cnt == c_REL_UART) begin
          w_state_nxt = ST_RUN;
          w_retry_nxt = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        O_RST_SYS_N   = w_lock_all;
        O_RST_VIDEO_N = w_lock_all;
        O_RST_UART_N  = w_lock_all;
        O_READY       = w_lock_all;
        if (!w_lock_all) begin
          if (c_AUTORETRY) begin
            // lock90 loss wins over any simultaneous stage-2 loss
            w_state_nxt = w_lock90 ? ST_RST2 : ST_RST1;
          end else begin
            w_state_nxt = ST_FAULT;
          end
        end
      end

      ST_FAULT: begin
        O_DCM1_RESET = 1'b1;
        O_DCM2_RESET = 1'b1;
        O_FAULT      = 1'b1;
      end

      default: begin
        O_DCM1_RESET = 1'b1;
        O_DCM2_RESET = 1'b1;
        w_state_nxt  = ST_RST1;
      end
    endcase

    // Every state entry starts the phase, stability and timeout counts afresh.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
      w_stb_nxt = '0;
      w_tmo_nxt = '0;
    end
  end

endmodule
`default_nettype wire
